// File: rtl/dark_busarb_if.sv
// Bus bundle for the two-master / one-slave arbiter.
// The arbiter acts as the slave of both masters, so it takes the slave modport.
interface dark_busarb_if #(
   parameter int AW = 32
);
   logic          M0_REQ;
   logic          M0_WR;
   logic [AW-1:0] M0_ADDR;
   logic [31:0]   M0_WDATA;
   logic [31:0]   M0_RDATA;
   logic          M0_ACK;

   logic          M1_REQ;
   logic          M1_WR;
   logic [AW-1:0] M1_ADDR;
   logic [31:0]   M1_WDATA;
   logic [31:0]   M1_RDATA;
   logic          M1_ACK;

   logic          S_EN;
   logic          S_WR;
   logic [AW-1:0] S_ADDR;
   logic [31:0]   S_WDATA;
   logic [31:0]   S_RDATA;

   logic [1:0]    GNT;

   modport slave (
      input  M0_REQ, M0_WR, M0_ADDR, M0_WDATA,
      output M0_RDATA, M0_ACK,
      input  M1_REQ, M1_WR, M1_ADDR, M1_WDATA,
      output M1_RDATA, M1_ACK,
      output S_EN, S_WR, S_ADDR, S_WDATA,
      input  S_RDATA,
      output GNT
   );

   modport master (
      output M0_REQ, M0_WR, M0_ADDR, M0_WDATA,
      input  M0_RDATA, M0_ACK,
      output M1_REQ, M1_WR, M1_ADDR, M1_WDATA,
      input  M1_RDATA, M1_ACK,
      input  S_EN, S_WR, S_ADDR, S_WDATA,
      output S_RDATA,
      input  GNT
   );
endinterface

// File: rtl/dark_busarb.sv
// Two-master round-robin arbiter in front of a single slave with WAITS extra
// wait cycles per access; one transaction every WAITS+3 cycles.
module dark_busarb #(
   parameter int WAITS = 1,
   parameter int AW    = 32
) (
   input  logic         CLK,
   input  logic         RES,
   dark_busarb_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t        r_state;
   state_t        w_nextState;

   logic [3:0]    r_cnt;
   logic          r_last;
   logic [1:0]    r_gnt;
   logic          r_sWr;
   logic [AW-1:0] r_sAddr;
   logic [31:0]   r_sWdata;
   logic [31:0]   r_m0Rdata;
   logic [31:0]   r_m1Rdata;

   logic          w_grant;
   logic          w_winner;
   logic          w_lastBeat;
   logic          w_sEn;
   logic          w_m0Ack;
   logic          w_m1Ack;

   always_ff @(posedge CLK) begin
      if (!RES) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // w_winner: 0 selects M0, 1 selects M1; on a tie the master that did not go last wins
   always_comb begin
      w_nextState = r_state;
      w_grant     = 1'b0;
      w_winner    = 1'b0;
      w_lastBeat  = 1'b0;
      w_sEn       = 1'b0;
      w_m0Ack     = 1'b0;
      w_m1Ack     = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.M0_REQ || bus.M1_REQ) begin
               w_grant     = 1'b1;
               w_nextState = BUSY;
               if (bus.M0_REQ && bus.M1_REQ) begin
                  w_winner = ~r_last;
               end else begin
                  w_winner = bus.M1_REQ;
               end
            end
         end
         BUSY: begin
            w_sEn = 1'b1;
            if (r_cnt == 4'd0) begin
               w_lastBeat  = 1'b1;
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_m0Ack     = r_gnt[0];
            w_m1Ack     = r_gnt[1];
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RES) begin
         r_cnt     <= 4'd0;
         r_last    <= 1'b1;
         r_gnt     <= 2'b00;
         r_sWr     <= 1'b0;
         r_sAddr   <= '0;
         r_sWdata  <= 32'd0;
         r_m0Rdata <= 32'd0;
         r_m1Rdata <= 32'd0;
      end else begin
         if (w_grant) begin
            r_gnt    <= w_winner ? 2'b10 : 2'b01;
            r_last   <= w_winner;
            r_cnt    <= 4'(WAITS);
            r_sWr    <= w_winner ? bus.M1_WR    : bus.M0_WR;
            r_sAddr  <= w_winner ? bus.M1_ADDR  : bus.M0_ADDR;
            r_sWdata <= w_winner ? bus.M1_WDATA : bus.M0_WDATA;
         end else if (w_sEn && !w_lastBeat) begin
            r_cnt <= r_cnt - 4'd1;
         end
         // Read data is only valid on the final slave cycle
         if (w_lastBeat && !r_sWr) begin
            if (r_gnt[0]) begin
               r_m0Rdata <= bus.S_RDATA;
            end
            if (r_gnt[1]) begin
               r_m1Rdata <= bus.S_RDATA;
            end
         end
         if (r_state == DONE) begin
            r_gnt <= 2'b00;
         end
      end
   end

   assign bus.S_EN     = w_sEn;
   assign bus.S_WR     = r_sWr;
   assign bus.S_ADDR   = r_sAddr;
   assign bus.S_WDATA  = r_sWdata;
   assign bus.M0_ACK   = w_m0Ack;
   assign bus.M1_ACK   = w_m1Ack;
   assign bus.M0_RDATA = r_m0Rdata;
   assign bus.M1_RDATA = r_m1Rdata;
   assign bus.GNT      = r_gnt;

endmodule
